// File: rtl/mole_spawner.sv
// mole_spawner: multi-mole whack-a-mole engine with LFSR placement, per-mole lifetime, hit/miss events and saturating score.
module mole_spawner #(
  parameter int NUM_HOLES = 16,
  parameter int MAX_ACTIVE = 2,
  parameter int LIFE_TICKS = 8,
  parameter int SPAWN_TICKS = 3,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 enable_i,
  input  logic                 tick_i,
  input  logic [NUM_HOLES-1:0] whack_i,
  output logic [NUM_HOLES-1:0] mole_o,
  output logic                 hit_o,
  output logic                 miss_o,
  output logic [2:0]           active_count_o,
  output logic [7:0]           score_o
);
  localparam int HW = $clog2(NUM_HOLES);
  logic [15:0] lfsr;
  logic [7:0] spawn_cnt;
  logic [MAX_ACTIVE-1:0] valid, valid_n, whacked, expired;
  logic [HW-1:0] hole [MAX_ACTIVE];
  logic [HW-1:0] hole_n [MAX_ACTIVE];
  logic [7:0] life [MAX_ACTIVE];
  logic [7:0] life_n [MAX_ACTIVE];
  logic [NUM_HOLES-1:0] occ, occ_n;
  logic [HW-1:0] cand;
  logic spawn, cand_ok, placed;
  logic [2:0] hits, count_n;
  logic [8:0] score_sum;
  always_comb begin
    cand = lfsr[HW-1:0];
    spawn = enable_i && tick_i && spawn_cnt == 8'(SPAWN_TICKS - 1);
    occ = '0;
    for (int s = 0; s < MAX_ACTIVE; s++) if (valid[s]) occ[hole[s]] = 1'b1;
    // occupancy and free-slot search use registered state, so slots freed this cycle stay unavailable
    cand_ok = spawn && int'(cand) < NUM_HOLES && !occ[cand] && !(&valid);
    valid_n = valid;
    hole_n = hole;
    life_n = life;
    whacked = '0;
    expired = '0;
    hits = '0;
    for (int s = 0; s < MAX_ACTIVE; s++) begin
      whacked[s] = enable_i && valid[s] && whack_i[hole[s]];
      expired[s] = enable_i && tick_i && valid[s] && life[s] == 8'd0 && !whacked[s];
      if (whacked[s] || expired[s]) valid_n[s] = 1'b0;
      else if (enable_i && tick_i && valid[s]) life_n[s] = life[s] - 8'd1;
      hits = hits + 3'(whacked[s]);
    end
    placed = 1'b0;
    for (int s = 0; s < MAX_ACTIVE; s++) begin
      if (cand_ok && !valid[s] && !placed) begin
        valid_n[s] = 1'b1;
        hole_n[s] = cand;
        life_n[s] = 8'(LIFE_TICKS - 1);
        placed = 1'b1;
      end
    end
    occ_n = '0;
    count_n = '0;
    for (int s = 0; s < MAX_ACTIVE; s++) begin
      if (valid_n[s]) occ_n[hole_n[s]] = 1'b1;
      count_n = count_n + 3'(valid_n[s]);
    end
    score_sum = {1'b0, score_o} + 9'(hits);
  end
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      lfsr <= LFSR_SEED;
      spawn_cnt <= '0;
      valid <= '0;
      hole <= '{default: '0};
      life <= '{default: '0};
      mole_o <= '0;
      hit_o <= 1'b0;
      miss_o <= 1'b0;
      active_count_o <= '0;
      score_o <= '0;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      if (enable_i && tick_i) spawn_cnt <= spawn ? 8'd0 : spawn_cnt + 8'd1;
      valid <= valid_n;
      hole <= hole_n;
      life <= life_n;
      mole_o <= enable_i ? occ_n : '0;
      hit_o <= |whacked;
      miss_o <= |expired;
      active_count_o <= count_n;
      score_o <= score_sum[8] ? 8'hFF : score_sum[7:0];
    end
  end
endmodule

// File: tb/tb_mole_spawner.sv
// tb_mole_spawner: scenario tasks checked against a per-hole behavioural model of the game rules.
module tb_mole_spawner;
  localparam int NH = 16, MAXA = 2, LIFE = 4, SPAWN = 2;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, tick = 1'b0;
  logic [15:0] whack = '0, mole;
  logic hit, miss;
  logic [2:0] cnt;
  logic [7:0] score;
  int vectors = 0, miscompares = 0;
  int m_life [NH];
  int m_cnt, m_score;
  logic [15:0] m_lfsr, taps;
  logic [15:0] e_mole;
  logic e_hit, e_miss;
  logic [2:0] e_cnt;
  logic [7:0] e_score;
  logic prev_en = 1'b0;

  mole_spawner #(.NUM_HOLES(NH), .MAX_ACTIVE(MAXA), .LIFE_TICKS(LIFE), .SPAWN_TICKS(SPAWN), .LFSR_SEED(16'hACE1)) dut (
    .clock_i(clk), .reset_i(rst_n), .enable_i(en), .tick_i(tick), .whack_i(whack),
    .mole_o(mole), .hit_o(hit), .miss_o(miss), .active_count_o(cnt), .score_o(score));

  always #5 clk = ~clk;

  function automatic logic [28:0] dut_v();
    return {mole, hit, miss, cnt, score};
  endfunction
  function automatic logic [28:0] exp_v();
    return {e_mole, e_hit, e_miss, e_cnt, e_score};
  endfunction
  function automatic string show(input logic [28:0] v);
    return $sformatf("mole=%h hit=%b miss=%b cnt=%0d score=%0d", v[28:13], v[12], v[11], v[10:8], v[7:0]);
  endfunction

  task automatic model_reset();
    foreach (m_life[h]) m_life[h] = -1;
    m_cnt = 0;
    m_score = 0;
    m_lfsr = 16'hACE1;
    // polynomial x^16+x^14+x^13+x^11+1 in right-shifting Galois form: term x^k taps bit k-1
    taps = 16'((1 << 15) | (1 << 13) | (1 << 12) | (1 << 10));
    {e_mole, e_hit, e_miss, e_cnt, e_score} = '0;
  endtask

  task automatic step(input logic ena, input logic tk, input logic [15:0] wh);
    logic [15:0] up;
    int hits, n_up;
    logic mis, sp;
    logic [3:0] cand;
    en = ena; tick = tk; whack = wh;
    for (int h = 0; h < NH; h++) up[h] = m_life[h] >= 0;
    n_up = $countones(up);
    hits = 0; mis = 1'b0;
    cand = m_lfsr[3:0];
    if (ena) begin
      sp = tk && m_cnt == SPAWN - 1;
      for (int h = 0; h < NH; h++) begin
        if (up[h] && wh[h]) begin m_life[h] = -1; hits++; end
        else if (up[h] && tk) begin
          if (m_life[h] == 0) begin m_life[h] = -1; mis = 1'b1; end
          else m_life[h]--;
        end
      end
      if (sp && n_up < MAXA && !up[cand]) m_life[cand] = LIFE - 1;
      if (tk) m_cnt = sp ? 0 : m_cnt + 1;
      m_score = m_score + hits > 255 ? 255 : m_score + hits;
    end
    for (int h = 0; h < NH; h++) up[h] = m_life[h] >= 0;
    e_mole = ena ? up : 16'h0;
    e_hit = hits > 0;
    e_miss = mis;
    e_cnt = 3'($countones(up));
    e_score = 8'(m_score);
    m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? taps : 16'h0);
    prev_en = ena;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; tick = 1'b1; whack = 16'hFFFF;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (dut_v() !== 29'h0) begin
        miscompares++;
        $display("FAIL reset[%0d]: got %s, want all zero", i, show(dut_v()));
      end
    end
    whack = '0;
  endtask

  task automatic test_first_spawn();
    logic [15:0] l1;
    rst_n = 1'b1;
    l1 = (16'hACE1 >> 1) ^ 16'hB400;
    step(1, 1, 0);
    step(1, 1, 0);
    vectors++;
    if ({mole, cnt, hit, miss} !== {16'h1 << l1[3:0], 3'd1, 2'b00}) begin
      miscompares++;
      $display("FAIL first_spawn: got %s, want mole=%h cnt=1 no hit/miss", show(dut_v()), 16'h1 << l1[3:0]);
    end
  endtask

  task automatic test_expiry();
    for (int i = 1; i <= 4; i++) begin
      step(1, 1, 0);
      vectors++;
      if ({mole[0], miss} !== (i == 4 ? 2'b01 : 2'b10)) begin
        miscompares++;
        $display("FAIL expiry[%0d]: got mole0=%b miss=%b, want mole0=%b miss=%b", i, mole[0], miss, i != 4, i == 4);
      end
      vectors++;
      if (dut_v() !== exp_v()) begin
        miscompares++;
        $display("FAIL expiry_model[%0d]: got %s, want %s", i, show(dut_v()), show(exp_v()));
      end
    end
  endtask

  task automatic test_capacity();
    logic seen2 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 0);
      seen2 |= cnt == 3'd2;
      vectors++;
      if (cnt > 3'd2 || dut_v() !== exp_v()) begin
        miscompares++;
        $display("FAIL capacity[%0d]: got %s, want %s (cnt<=2)", i, show(dut_v()), show(exp_v()));
      end
    end
    vectors++;
    if (seen2 !== 1'b1) begin
      miscompares++;
      $display("FAIL capacity_full: never saw cnt=2, want it reached");
    end
  endtask

  task automatic test_whack();
    int h, s0;
    for (int i = 0; i < 20 && e_mole == 0; i++) step(1, 1, 0);
    h = 0;
    while (h < NH - 1 && !e_mole[h]) h++;
    s0 = m_score;
    step(1, 1, 16'h1 << h);
    vectors++;
    if ({hit, mole[h], score} !== {1'b1, 1'b0, 8'(s0 + 1)} || dut_v() !== exp_v()) begin
      miscompares++;
      $display("FAIL whack_hit h=%0d: got %s, want %s", h, show(dut_v()), show(exp_v()));
    end
    h = 0;
    while (h < NH - 1 && e_mole[h]) h++;
    step(1, 1, 16'h1 << h);
    vectors++;
    if ({hit, score} !== {1'b0, 8'(s0 + 1)} || dut_v() !== exp_v()) begin
      miscompares++;
      $display("FAIL whack_empty h=%0d: got %s, want %s", h, show(dut_v()), show(exp_v()));
    end
  endtask

  task automatic test_multi_whack();
    int s0, hz;
    logic [15:0] both;
    for (int i = 0; i < 30 && e_cnt != 3'd2; i++) step(1, 1, 0);
    both = e_mole;
    s0 = m_score;
    step(1, 1, both);
    vectors++;
    if ({hit, score, |(mole & both)} !== {1'b1, 8'(s0 + 2), 1'b0} || dut_v() !== exp_v()) begin
      miscompares++;
      $display("FAIL multi_whack: got %s, want %s (score %0d)", show(dut_v()), show(exp_v()), s0 + 2);
    end
    hz = -1;
    for (int i = 0; i < 30 && hz < 0; i++) begin
      step(1, 1, 0);
      foreach (m_life[h]) if (m_life[h] == 0) hz = h;
    end
    s0 = m_score;
    step(1, 1, 16'h1 << hz);
    vectors++;
    if ({hit, miss, score} !== {2'b10, 8'(s0 + 1)} || dut_v() !== exp_v()) begin
      miscompares++;
      $display("FAIL whack_on_expiry h=%0d: got %s, want %s", hz, show(dut_v()), show(exp_v()));
    end
  endtask

  task automatic test_saturation();
    int extra = 0;
    for (int i = 0; i < 4000 && extra < 20; i++) begin
      step(1, 1, e_mole);
      if (m_score == 255) extra++;
      vectors++;
      if (dut_v() !== exp_v()) begin
        miscompares++;
        $display("FAIL saturation[%0d]: got %s, want %s", i, show(dut_v()), show(exp_v()));
      end
    end
    vectors++;
    if (score !== 8'd255) begin
      miscompares++;
      $display("FAIL saturation_final: got score=%0d, want 255", score);
    end
  endtask

  task automatic test_pause();
    logic [15:0] held;
    for (int i = 0; i < 20 && e_cnt == 0; i++) step(1, 1, 0);
    held = e_mole;
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 16'($urandom));
      vectors++;
      if ({mole, hit, miss} !== 18'h0 || dut_v() !== exp_v()) begin
        miscompares++;
        $display("FAIL pause[%0d]: got %s, want %s", i, show(dut_v()), show(exp_v()));
      end
    end
    step(1, 0, 0);
    vectors++;
    if (mole !== held || dut_v() !== exp_v()) begin
      miscompares++;
      $display("FAIL resume: got %s, want mole=%h %s", show(dut_v()), held, show(exp_v()));
    end
  endtask

  task automatic test_random();
    logic [15:0] wh;
    for (int i = 0; i < 1500; i++) begin
      wh = prev_en ? (e_mole & 16'($urandom)) | ($urandom_range(0, 3) == 0 ? 16'h1 << $urandom_range(0, 15) : 16'h0) : 16'h0;
      step($urandom_range(0, 4) != 0, $urandom_range(0, 9) < 7, wh);
      vectors++;
      if (dut_v() !== exp_v()) begin
        miscompares++;
        $display("FAIL random[%0d]: got %s, want %s", i, show(dut_v()), show(exp_v()));
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) step(1, 1, e_mole & 16'h00FF);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (dut_v() !== 29'h0) begin
      miscompares++;
      $display("FAIL reset_mid: got %s, want all zero", show(dut_v()));
    end
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 0);
      vectors++;
      if (dut_v() !== exp_v()) begin
        miscompares++;
        $display("FAIL after_reset[%0d]: got %s, want %s", i, show(dut_v()), show(exp_v()));
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_spawn();
    test_expiry();
    test_capacity();
    test_whack();
    test_multi_whack();
    test_saturation();
    test_pause();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mole_spawner.md
Name: mole_spawner

Overview:
- Parametrised successor to the single-mole handler for the whack-a-mole game.
- Drives up to MAX_ACTIVE simultaneous moles across NUM_HOLES holes, with LFSR-random placement and a per-mole lifetime.
- Resolves per-hole whacks into hit/miss events and a saturating score.
- Sits between the game-timing tick generator, the debounced button/switch matrix and the LED/display driver.

Parameters:
- NUM_HOLES, 16: number of holes; legal range 2..32.
- MAX_ACTIVE, 2: maximum moles up at once; legal range 1..4.
- LIFE_TICKS, 8: ticks a mole stays up before expiring; legal range 1..255.
- SPAWN_TICKS, 3: ticks between spawn attempts; legal range 1..255.
- LFSR_SEED, 16'hACE1: LFSR reset value; must be non-zero.

Ports:
- clock_i  in  1  system clock.
- reset_i  in  1  asynchronous, active-low reset.
- enable_i  in  1  game running; low pauses the block.
- tick_i  in  1  one-cycle game time-base pulse.
- whack_i  in  NUM_HOLES  per-hole whack pulses, already debounced and one cycle wide.
- mole_o  out  NUM_HOLES  one bit per raised mole (registered).
- hit_o  out  1  pulse: at least one mole whacked this event.
- miss_o  out  1  pulse: at least one mole expired unwhacked.
- active_count_o  out  3  number of valid slots.
- score_o  out  8  hits accumulated, saturating at 255.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. The ports are clock_i and reset_i.
- Reset (reset_i=0): all slots invalid, all counters 0, LFSR=LFSR_SEED. Outputs: mole_o=0, hit_o=0, miss_o=0, active_count_o=0, score_o=0. Reset applies immediately at any point, including mid-game.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Advances every clock out of reset, independent of enable_i.
- Candidate hole = LFSR[clog2(NUM_HOLES)-1:0]. If candidate >= NUM_HOLES, the attempt is skipped.
- Slots: MAX_ACTIVE entries, each holding {valid, hole index, 8-bit life counter}. mole_o[h]=1 iff some valid slot holds hole h.
- Spawn counter:
  - Increments on tick_i while enable_i=1.
  - On the tick where it equals SPAWN_TICKS-1, a spawn attempt occurs and the counter returns to 0, whether or not the attempt succeeds.
- Spawn attempt:
  - Fills the lowest-index invalid slot with the candidate hole and sets life=LIFE_TICKS-1.
  - Skipped if all slots are valid, or if the candidate hole is already occupied (checked against registered state).
  - The new mole is visible on mole_o the cycle after the spawn tick.
- Expiry:
  - On each tick with enable_i=1, every valid slot with life>0 decrements.
  - A valid slot with life==0 on a tick is invalidated and asserts miss_o for one cycle, the cycle after that tick.
- Whack:
  - whack_i[h]=1 while enable_i=1 and mole_o[h]=1 invalidates that slot.
  - hit_o pulses the next cycle; score_o += number of moles hit that cycle, saturating at 255.
  - Whacks on empty holes are ignored: no hit, no miss, no score change.
- Simultaneous events:
  - Whack and expiry of the same slot in one cycle: the whack wins (hit, no miss).
  - Multiple whacks in one cycle: all matching moles are cleared, hit_o is a single pulse, and score adds the full count.
  - A slot freed in a cycle is not reusable until the next cycle; a spawn on that cycle goes to another free slot or is skipped.
  - A whack on the cycle a mole spawns does not hit the new mole.
  - Hit and miss may both pulse in the same cycle.
- enable_i=0:
  - Spawn and life counters freeze; whacks are ignored.
  - mole_o is forced to 0 while slot state is held.
  - hit_o and miss_o are 0.
  - Returning enable_i to 1 resumes from the held state with no other effect.
- active_count_o: registered popcount of valid slots.
- Latency: every output is registered, one cycle after the causing event.

Test Plan:
Bench setup for all scenarios: NUM_HOLES=16, MAX_ACTIVE=2, LIFE_TICKS=4, SPAWN_TICKS=2, tick_i held at 1.
1. Reset, then release with enable_i=1 -> first mole at hole LFSR[3:0] two cycles after release; active_count_o=1; no hit or miss.
2. No whacks for 4 ticks after a spawn -> that mole clears and miss_o pulses exactly once; mole_o is otherwise unchanged.
3. Spawns continue with no whacks -> active_count_o never exceeds 2; a third attempt is skipped while both slots are valid.
4. whack_i=16'h0001 with mole_o=16'h0001 -> mole_o[0]=0 and hit_o=1 next cycle; score_o 0->1. Whack on an empty hole -> no change.
5. Whack both raised moles in one cycle -> one hit_o pulse, score_o +2. Whack on a mole's expiry cycle -> hit_o=1, miss_o=0. Force score_o=255 and hit again -> score_o stays 255.
6. enable_i=0 for 10 cycles -> mole_o=0, life counters held. Re-enable -> the same moles reappear with their remaining life. Assert reset_i=0 mid-game -> all outputs 0 immediately.
